// File: rtl/seg7_time_monitor.sv
// -----------------------------------------------------------------------------
// seg7_time_monitor
//
// Receive-side checker for the four 7-segment digit buses of a digital clock
// (minutes units/tens, hours units/tens). The segment lines are synchronised,
// deglitched by a stability filter and decoded back to BCD. Every accepted
// display change is range-checked and classified as a legal one-step advance
// (tick), a set/reset jump (jump), or an illegal frame (err).
//
// Ports
//   clk_inbuilt   system clock, rising edge
//   reset         asynchronous active-low reset
//   D_M2/D_M1     minutes units / tens segments {a..g}, bit6 = a, active-high
//   D_H2/D_H1     hours units / tens segments
//   bcd_m2..h1    decoded digits of the last accepted frame (4'hF = unknown)
//   time_idx      mixed-radix index of the last legal accepted time
//   valid         last accepted frame was legal
//   tick          1-cycle pulse, legal +1 advance (including max -> 0 wrap)
//   jump          1-cycle pulse, legal change that is not +1
//   err           1-cycle pulse, accepted frame illegal
//   err_code      1 = unknown segment pattern, 2 = digit above max, else 0
//   err_cnt       saturating count of err pulses
//   o_dbg_state   current tracking FSM state (0 = IDLE, 1 = TRACK)
// -----------------------------------------------------------------------------
module seg7_time_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_M2        = 9,
  parameter int MAX_M1        = 5,
  parameter int MAX_H2        = 3,
  parameter int MAX_H1        = 2,
  parameter int IDX_W         = 10
) (
  input  logic             clk_inbuilt,
  input  logic             reset,
  input  logic [6:0]       D_M2,
  input  logic [6:0]       D_M1,
  input  logic [6:0]       D_H2,
  input  logic [6:0]       D_H1,
  output logic [3:0]       bcd_m2,
  output logic [3:0]       bcd_m1,
  output logic [3:0]       bcd_h2,
  output logic [3:0]       bcd_h1,
  output logic [IDX_W-1:0] time_idx,
  output logic             valid,
  output logic             tick,
  output logic             jump,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [7:0]       err_cnt,
  output logic             o_dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [7:0]       STAB_N   = 8'(STABLE_CYCLES);
  localparam logic [7:0]       STAB_NM1 = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0]       LIM_M2   = 4'(MAX_M2);
  localparam logic [3:0]       LIM_M1   = 4'(MAX_M1);
  localparam logic [3:0]       LIM_H2   = 4'(MAX_H2);
  localparam logic [3:0]       LIM_H1   = 4'(MAX_H1);
  localparam logic [IDX_W-1:0] RAD_M2   = IDX_W'(MAX_M2 + 1);
  localparam logic [IDX_W-1:0] RAD_M1   = IDX_W'(MAX_M1 + 1);
  localparam logic [IDX_W-1:0] RAD_H2   = IDX_W'(MAX_H2 + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX  =
    IDX_W'((MAX_H1 + 1) * (MAX_H2 + 1) * (MAX_M1 + 1) * (MAX_M2 + 1) - 1);

  // Returns {unknown, bcd}; unknown patterns decode to 4'hF.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111110: res = {1'b0, 4'd0};
      7'b0110000: res = {1'b0, 4'd1};
      7'b1101101: res = {1'b0, 4'd2};
      7'b1111001: res = {1'b0, 4'd3};
      7'b0110011: res = {1'b0, 4'd4};
      7'b1011011: res = {1'b0, 4'd5};
      7'b1011111: res = {1'b0, 4'd6};
      7'b1110000: res = {1'b0, 4'd7};
      7'b1111111: res = {1'b0, 4'd8};
      7'b1111011: res = {1'b0, 4'd9};
      default:    res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and stability filter
  // r_s3 holds the previous s2 sample so a change can be detected.
  // ---------------------------------------------------------------------------
  logic [27:0] r_s1;
  logic [27:0] r_s2;
  logic [27:0] r_s3;
  logic [7:0]  r_stab;
  logic [27:0] r_last;
  state_t      r_state;

  logic        w_same;
  logic        w_accept;

  assign w_same   = (r_s2 == r_s3);
  // Accept on the edge where the counter steps up to STABLE_CYCLES, so the
  // result registers land on that same edge.
  assign w_accept = w_same && (r_stab == STAB_NM1) && (r_s2 != r_last);

  always_ff @(posedge clk_inbuilt or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_stab <= '0;
    end else begin
      r_s1 <= {D_H1, D_H2, D_M1, D_M2};
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_same) begin
        r_stab <= '0;
      end else if (r_stab != STAB_N) begin
        r_stab <= r_stab + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode and range check of the candidate frame (r_s2)
  // ---------------------------------------------------------------------------
  logic [4:0]       w_dec_m2;
  logic [4:0]       w_dec_m1;
  logic [4:0]       w_dec_h2;
  logic [4:0]       w_dec_h1;
  logic             w_unknown;
  logic             w_over;
  logic             w_legal;
  logic [IDX_W-1:0] w_new_idx;
  logic             w_is_step;

  assign w_dec_m2 = seg_decode(r_s2[6:0]);
  assign w_dec_m1 = seg_decode(r_s2[13:7]);
  assign w_dec_h2 = seg_decode(r_s2[20:14]);
  assign w_dec_h1 = seg_decode(r_s2[27:21]);

  assign w_unknown = w_dec_m2[4] | w_dec_m1[4] | w_dec_h2[4] | w_dec_h1[4];
  assign w_over    = (w_dec_m2[3:0] > LIM_M2) | (w_dec_m1[3:0] > LIM_M1) |
                     (w_dec_h2[3:0] > LIM_H2) | (w_dec_h1[3:0] > LIM_H1);
  assign w_legal   = !w_unknown && !w_over;

  assign w_new_idx = ((IDX_W'(w_dec_h1[3:0]) * RAD_H2 + IDX_W'(w_dec_h2[3:0])) * RAD_M1
                      + IDX_W'(w_dec_m1[3:0])) * RAD_M2 + IDX_W'(w_dec_m2[3:0]);

  // +1 advance, including the wrap from the last time of day back to zero.
  assign w_is_step = (w_new_idx == time_idx + IDX_ONE) ||
                     ((time_idx == IDX_MAX) && (w_new_idx == '0));

  // ---------------------------------------------------------------------------
  // Tracking FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_inbuilt or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_last   <= '0;
      bcd_m2   <= '0;
      bcd_m1   <= '0;
      bcd_h2   <= '0;
      bcd_h1   <= '0;
      time_idx <= '0;
      valid    <= 1'b0;
      tick     <= 1'b0;
      jump     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
      err_cnt  <= '0;
    end else begin
      tick <= 1'b0;
      jump <= 1'b0;
      err  <= 1'b0;
      if (w_accept) begin
        r_last <= r_s2;
        bcd_m2 <= w_dec_m2[3:0];
        bcd_m1 <= w_dec_m1[3:0];
        bcd_h2 <= w_dec_h2[3:0];
        bcd_h1 <= w_dec_h1[3:0];
        if (w_legal) begin
          valid    <= 1'b1;
          err_code <= 2'd0;
          time_idx <= w_new_idx;
          case (r_state)
            ST_IDLE: begin
              // First legal frame only arms the tracker.
              r_state <= ST_TRACK;
            end
            ST_TRACK: begin
              if (w_is_step) begin
                tick <= 1'b1;
              end else begin
                jump <= 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end else begin
          // time_idx keeps the last legal time; tracker must re-arm.
          valid    <= 1'b0;
          err      <= 1'b1;
          err_code <= w_unknown ? 2'd1 : 2'd2;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_time_monitor.sv
// -----------------------------------------------------------------------------
// tb_seg7_time_monitor
//
// Self-checking bench for seg7_time_monitor with the default parameters
// (24h-style radix 3/4/6/10, STABLE_CYCLES = 4). A behavioural model keeps the
// last accepted frame, the armed flag, the last legal time index and the error
// counter, and predicts which pulse (if any) each driven frame produces and on
// which edge it appears.
// -----------------------------------------------------------------------------
module tb_seg7_time_monitor;

  localparam int IDX_W   = 10;
  localparam int MAX_IDX = 3 * 4 * 6 * 10 - 1;   // 719
  localparam int WIN     = 10;                    // edges watched per frame

  logic             clk_inbuilt;
  logic             reset;
  logic [6:0]       D_M2;
  logic [6:0]       D_M1;
  logic [6:0]       D_H2;
  logic [6:0]       D_H1;
  logic [3:0]       bcd_m2;
  logic [3:0]       bcd_m1;
  logic [3:0]       bcd_h2;
  logic [3:0]       bcd_h1;
  logic [IDX_W-1:0] time_idx;
  logic             valid;
  logic             tick;
  logic             jump;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       err_cnt;
  logic             o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011};
  int max_dig [4] = '{9, 5, 3, 2};   // m2, m1, h2, h1

  // Reference model state
  logic [27:0] m_last;
  bit          m_armed;
  int          m_idx;
  bit          m_valid;
  int          m_bcd [4];
  int          m_code;
  int          m_cnt;

  seg7_time_monitor dut (
    .clk_inbuilt (clk_inbuilt),
    .reset       (reset),
    .D_M2        (D_M2),
    .D_M1        (D_M1),
    .D_H2        (D_H2),
    .D_H1        (D_H1),
    .bcd_m2      (bcd_m2),
    .bcd_m1      (bcd_m1),
    .bcd_h2      (bcd_h2),
    .bcd_h1      (bcd_h1),
    .time_idx    (time_idx),
    .valid       (valid),
    .tick        (tick),
    .jump        (jump),
    .err         (err),
    .err_code    (err_code),
    .err_cnt     (err_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_inbuilt = 1'b0;
  always #5 clk_inbuilt = ~clk_inbuilt;

  // ---------------- model ----------------
  task automatic model_reset();
    m_last  = '0;
    m_armed = 0;
    m_idx   = 0;
    m_valid = 0;
    m_code  = 0;
    m_cnt   = 0;
    for (int d = 0; d < 4; d++) m_bcd[d] = 0;
  endtask

  function automatic logic [27:0] frame_of(input int h1, input int h2, input int m1, input int m2);
    return {pat[h1], pat[h2], pat[m1], pat[m2]};
  endfunction

  function automatic logic [27:0] frame_of_idx(input int idx);
    return frame_of(idx / 240, (idx / 60) % 4, (idx / 10) % 6, idx % 10);
  endfunction

  // kind: 0 none, 1 tick, 2 jump, 3 err
  task automatic model_frame(input logic [27:0] f, output int kind);
    bit unk;
    bit over;
    int idx;
    kind = 0;
    if (f == m_last) return;
    m_last = f;
    unk = 0;
    over = 0;
    for (int d = 0; d < 4; d++) begin
      logic [6:0] seg;
      seg = f[d*7 +: 7];
      m_bcd[d] = 15;
      for (int v = 0; v < 10; v++) if (pat[v] == seg) m_bcd[d] = v;
      if (m_bcd[d] == 15) unk = 1;
      else if (m_bcd[d] > max_dig[d]) over = 1;
    end
    if (unk || over) begin
      m_valid = 0;
      m_code  = unk ? 1 : 2;
      if (m_cnt < 255) m_cnt++;
      m_armed = 0;
      kind    = 3;
    end else begin
      idx     = ((m_bcd[3] * 4 + m_bcd[2]) * 6 + m_bcd[1]) * 10 + m_bcd[0];
      m_valid = 1;
      m_code  = 0;
      if (m_armed) kind = (idx == m_idx + 1 || (m_idx == MAX_IDX && idx == 0)) ? 1 : 2;
      m_armed = 1;
      m_idx   = idx;
    end
  endtask

  // ---------------- driver ----------------
  // Drives a frame, watches WIN edges and reports the first pulse seen,
  // the total number of pulses and the first edge where valid changed.
  task automatic drive_frame(input logic [27:0] f, output int exp_kind,
                             output int got_kind, output int got_edge,
                             output int n_pulse, output int valid_edge);
    logic v0;
    model_frame(f, exp_kind);
    @(negedge clk_inbuilt);
    {D_H1, D_H2, D_M1, D_M2} = f;
    v0 = valid;
    got_kind = 0;
    got_edge = 0;
    n_pulse = 0;
    valid_edge = 0;
    for (int e = 1; e <= WIN; e++) begin
      @(posedge clk_inbuilt);
      #1;
      if (tick || jump || err) begin
        n_pulse += int'(tick) + int'(jump) + int'(err);
        if (got_edge == 0) begin
          got_edge = e;
          got_kind = tick ? 1 : (jump ? 2 : 3);
        end
      end
      if (valid_edge == 0 && valid !== v0) valid_edge = e;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    reset = 1'b0;
    {D_H1, D_H2, D_M1, D_M2} = '0;
    model_reset();
    repeat (3) @(negedge clk_inbuilt);
    reset = 1'b1;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk_inbuilt);
      #1;
      pulses += int'(tick) + int'(jump) + int'(err);
    end
    checks++;
    if ({bcd_h1, bcd_h2, bcd_m1, bcd_m2, time_idx, valid, err_code, err_cnt, o_dbg_state} !== '0 ||
        pulses != 0) begin
      errors++;
      $display("FAIL reset_outputs: bcd=%h idx=%0d valid=%b code=%0d cnt=%0d st=%b pulses=%0d, required all zero",
               {bcd_h1, bcd_h2, bcd_m1, bcd_m2}, time_idx, valid, err_code, err_cnt, o_dbg_state, pulses);
    end
  endtask

  task automatic test_first_and_tick();
    int ek, gk, ge, np, ve;
    drive_frame(frame_of(0, 0, 0, 0), ek, gk, ge, np, ve);
    checks++;
    if (ve != 7 || valid !== 1'b1 || time_idx !== 0 || np != 0 ||
        {bcd_h1, bcd_h2, bcd_m1, bcd_m2} !== 16'h0000 || o_dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: valid_edge=%0d valid=%b idx=%0d pulses=%0d bcd=%h st=%b, required 7 1 0 0 0000 1",
               ve, valid, time_idx, np, {bcd_h1, bcd_h2, bcd_m1, bcd_m2}, o_dbg_state);
    end
    drive_frame(frame_of(0, 0, 0, 1), ek, gk, ge, np, ve);
    checks++;
    if (gk != 1 || ge != 7 || np != 1 || time_idx !== 1 || bcd_m2 !== 4'd1) begin
      errors++;
      $display("FAIL first_tick: kind=%0d edge=%0d pulses=%0d idx=%0d m2=%0d, required 1 7 1 1 1",
               gk, ge, np, time_idx, bcd_m2);
    end
  endtask

  task automatic test_wrap();
    int ek, gk, ge, np, ve;
    drive_frame(frame_of(2, 3, 5, 9), ek, gk, ge, np, ve);
    checks++;
    if (gk != 2 || ge != 7 || time_idx !== 719) begin
      errors++;
      $display("FAIL set_2359: kind=%0d edge=%0d idx=%0d, required 2 7 719", gk, ge, time_idx);
    end
    drive_frame(frame_of(0, 0, 0, 0), ek, gk, ge, np, ve);
    checks++;
    if (gk != 1 || ge != 7 || np != 1 || time_idx !== 0) begin
      errors++;
      $display("FAIL wrap_tick: kind=%0d edge=%0d pulses=%0d idx=%0d, required 1 7 1 0", gk, ge, np, time_idx);
    end
  endtask

  task automatic test_jump();
    int ek, gk, ge, np, ve;
    drive_frame(frame_of(0, 0, 0, 5), ek, gk, ge, np, ve);
    drive_frame(frame_of(0, 0, 1, 7), ek, gk, ge, np, ve);
    checks++;
    if (gk != 2 || ge != 7 || np != 1 || time_idx !== 17 || bcd_m1 !== 4'd1 || bcd_m2 !== 4'd7) begin
      errors++;
      $display("FAIL jump_0017: kind=%0d edge=%0d pulses=%0d idx=%0d m1=%0d m2=%0d, required 2 7 1 17 1 7",
               gk, ge, np, time_idx, bcd_m1, bcd_m2);
    end
  endtask

  task automatic test_glitch();
    logic [IDX_W+16:0] snap;
    int pulses;
    snap = {time_idx, valid, bcd_h1, bcd_h2, bcd_m1, bcd_m2};
    @(negedge clk_inbuilt);
    D_M2 = pat[9];
    repeat (3) @(negedge clk_inbuilt);
    D_M2 = pat[7];
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk_inbuilt);
      #1;
      pulses += int'(tick) + int'(jump) + int'(err);
    end
    checks++;
    if (pulses != 0 || {time_idx, valid, bcd_h1, bcd_h2, bcd_m1, bcd_m2} !== snap) begin
      errors++;
      $display("FAIL glitch_reject: pulses=%0d state=%h, required 0 %h",
               pulses, {time_idx, valid, bcd_h1, bcd_h2, bcd_m1, bcd_m2}, snap);
    end
  endtask

  task automatic test_errors();
    int ek, gk, ge, np, ve;
    drive_frame(frame_of(0, 0, 6, 7), ek, gk, ge, np, ve);
    checks++;
    if (gk != 3 || ge != 7 || err_code !== 2'd2 || bcd_m1 !== 4'd6 || valid !== 1'b0 ||
        time_idx !== 17 || err_cnt !== 8'd1 || o_dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL range_err: kind=%0d edge=%0d code=%0d m1=%0d valid=%b idx=%0d cnt=%0d st=%b, required 3 7 2 6 0 17 1 0",
               gk, ge, err_code, bcd_m1, valid, time_idx, err_cnt, o_dbg_state);
    end
    drive_frame({pat[0], pat[0], pat[6], 7'b0000001}, ek, gk, ge, np, ve);
    checks++;
    if (gk != 3 || err_code !== 2'd1 || bcd_m2 !== 4'hF || bcd_m1 !== 4'd6 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL pattern_err: kind=%0d code=%0d m2=%h m1=%0d cnt=%0d, required 3 1 f 6 2",
               gk, err_code, bcd_m2, bcd_m1, err_cnt);
    end
    // Re-arm: first legal frame after an error gives no pulse.
    drive_frame(frame_of(0, 0, 1, 8), ek, gk, ge, np, ve);
    checks++;
    if (np != 0 || valid !== 1'b1 || err_code !== 2'd0 || time_idx !== 18) begin
      errors++;
      $display("FAIL rearm: pulses=%0d valid=%b code=%0d idx=%0d, required 0 1 0 18", np, valid, err_code, time_idx);
    end
  endtask

  task automatic test_random();
    int ek, gk, ge, np, ve;
    logic [27:0] f;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: f = frame_of_idx((m_idx + 1) % (MAX_IDX + 1));
        5, 6:          f = frame_of_idx($urandom_range(0, MAX_IDX));
        7, 8:          f = 28'($urandom);
        default:       f = m_last;
      endcase
      drive_frame(f, ek, gk, ge, np, ve);
      checks++;
      if (gk != ek || ge != ((ek != 0) ? 7 : 0) || np != ((ek != 0) ? 1 : 0) ||
          time_idx !== IDX_W'(m_idx) || valid !== m_valid || err_code !== 2'(m_code) ||
          err_cnt !== 8'(m_cnt) || bcd_m2 !== 4'(m_bcd[0]) || bcd_m1 !== 4'(m_bcd[1]) ||
          bcd_h2 !== 4'(m_bcd[2]) || bcd_h1 !== 4'(m_bcd[3])) begin
        errors++;
        $display("FAIL random_%0d: frame=%h kind=%0d edge=%0d np=%0d idx=%0d valid=%b code=%0d cnt=%0d bcd=%h%h%h%h, required kind=%0d idx=%0d valid=%b code=%0d cnt=%0d bcd=%h%h%h%h",
                 i, f, gk, ge, np, time_idx, valid, err_code, err_cnt, bcd_h1, bcd_h2, bcd_m1, bcd_m2,
                 ek, m_idx, m_valid, m_code, m_cnt, m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]);
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    int ek, gk, ge, np, ve;
    int bad_pulses;
    bad_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      drive_frame((i % 2 == 0) ? {4{7'b0000001}} : {4{7'b0000010}}, ek, gk, ge, np, ve);
      if (gk != 3 || np != 1) bad_pulses++;
    end
    checks++;
    if (err_cnt !== 8'd255 || err_cnt !== 8'(m_cnt) || bad_pulses != 0) begin
      errors++;
      $display("FAIL err_saturate: cnt=%0d bad_pulses=%0d, required 255 0", err_cnt, bad_pulses);
    end
    // Reset in the middle of a stability window.
    @(negedge clk_inbuilt);
    {D_H1, D_H2, D_M1, D_M2} = frame_of(1, 2, 3, 4);
    repeat (4) @(negedge clk_inbuilt);
    reset = 1'b0;
    {D_H1, D_H2, D_M1, D_M2} = '0;
    model_reset();
    #1;
    checks++;
    if (err_cnt !== 8'd0 || o_dbg_state !== 1'b0 || valid !== 1'b0 || time_idx !== 0) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d st=%b valid=%b idx=%0d, required 0 0 0 0",
               err_cnt, o_dbg_state, valid, time_idx);
    end
    repeat (2) @(negedge clk_inbuilt);
    reset = 1'b1;
    drive_frame(frame_of(1, 2, 3, 4), ek, gk, ge, np, ve);
    checks++;
    if (np != 0 || ve != 7 || time_idx !== IDX_W'(((1 * 4 + 2) * 6 + 3) * 10 + 4) || valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept: pulses=%0d valid_edge=%0d idx=%0d valid=%b, required 0 7 394 1",
               np, ve, time_idx, valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_and_tick();
    test_wrap();
    test_jump();
    test_glitch();
    test_errors();
    test_random();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
